// File: rtl/alu_181_pipelined.sv
// Two-stage pipelined 74181-style ALU with valid/ready handshakes on both sides
// and an internal accumulator that can stand in for operand A.
module alu_181_pipelined #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       select,
  input  logic             mode_control,
  input  logic             carry_in,
  input  logic             acc_sel,
  input  logic             acc_write,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] function_output,
  output logic             carry_out,
  output logic             overflow,
  output logic             comparator_output,
  output logic             zero_flag,
  output logic [WIDTH-1:0] accumulator
);

  logic             r_run;
  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic [3:0]       r_s1_sel;
  logic             r_s1_mode;
  logic             r_s1_carry_in;
  logic             r_s1_acc_sel;
  logic             r_s1_acc_write;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_ovf;
  logic             r_cmp;
  logic             r_zero;
  logic [WIDTH-1:0] r_acc;

  logic             w_s1_advance;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_op_a;
  logic [WIDTH-1:0] w_nb;
  logic [WIDTH-1:0] w_logic;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH:0]   w_sum;
  logic             w_cin;
  logic [WIDTH-1:0] w_f;
  logic             w_cout;
  logic             w_ovf;

  // r_run keeps in_ready low until the first clock after reset release
  assign w_s1_advance = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready     = r_run & (~r_s1_valid | w_s1_advance);
  assign w_in_fire    = in_valid & in_ready;

  assign w_op_a = r_s1_acc_sel ? r_acc : r_s1_a;
  assign w_nb   = ~r_s1_b;
  assign w_cin  = ~r_s1_carry_in;

  always_comb begin
    w_logic = '0;
    case (r_s1_sel)
      4'h0: w_logic = ~w_op_a;
      4'h1: w_logic = ~(w_op_a | r_s1_b);
      4'h2: w_logic = ~w_op_a & r_s1_b;
      4'h3: w_logic = '0;
      4'h4: w_logic = ~(w_op_a & r_s1_b);
      4'h5: w_logic = w_nb;
      4'h6: w_logic = w_op_a ^ r_s1_b;
      4'h7: w_logic = w_op_a & w_nb;
      4'h8: w_logic = ~w_op_a | r_s1_b;
      4'h9: w_logic = ~(w_op_a ^ r_s1_b);
      4'hA: w_logic = r_s1_b;
      4'hB: w_logic = w_op_a & r_s1_b;
      4'hC: w_logic = '1;
      4'hD: w_logic = w_op_a | w_nb;
      4'hE: w_logic = w_op_a | r_s1_b;
      default: w_logic = w_op_a;
    endcase
  end

  // Arithmetic ops are expressed as X + Y + cin; "-1" is an all-ones Y
  always_comb begin
    w_x = w_op_a;
    w_y = '0;
    case (r_s1_sel)
      4'h0: begin w_x = w_op_a;            w_y = '0;                 end
      4'h1: begin w_x = w_op_a | r_s1_b;   w_y = '0;                 end
      4'h2: begin w_x = w_op_a | w_nb;     w_y = '0;                 end
      4'h3: begin w_x = '0;                w_y = '1;                 end
      4'h4: begin w_x = w_op_a;            w_y = w_op_a & w_nb;      end
      4'h5: begin w_x = w_op_a | r_s1_b;   w_y = w_op_a & w_nb;      end
      4'h6: begin w_x = w_op_a;            w_y = w_nb;               end
      4'h7: begin w_x = w_op_a & w_nb;     w_y = '1;                 end
      4'h8: begin w_x = w_op_a;            w_y = w_op_a & r_s1_b;    end
      4'h9: begin w_x = w_op_a;            w_y = r_s1_b;             end
      4'hA: begin w_x = w_op_a | w_nb;     w_y = w_op_a & r_s1_b;    end
      4'hB: begin w_x = w_op_a & r_s1_b;   w_y = '1;                 end
      4'hC: begin w_x = w_op_a;            w_y = w_op_a;             end
      4'hD: begin w_x = w_op_a | r_s1_b;   w_y = w_op_a;             end
      4'hE: begin w_x = w_op_a | w_nb;     w_y = w_op_a;             end
      default: begin w_x = w_op_a;         w_y = '1;                 end
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};

  always_comb begin
    w_f    = w_sum[WIDTH-1:0];
    w_cout = ~w_sum[WIDTH];
    w_ovf  = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);
    if (r_s1_mode) begin
      w_f    = w_logic;
      w_cout = 1'b1;
      w_ovf  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run          <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_a         <= '0;
      r_s1_b         <= '0;
      r_s1_sel       <= '0;
      r_s1_mode      <= 1'b0;
      r_s1_carry_in  <= 1'b0;
      r_s1_acc_sel   <= 1'b0;
      r_s1_acc_write <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (w_in_fire) begin
        r_s1_valid     <= 1'b1;
        r_s1_a         <= a;
        r_s1_b         <= b;
        r_s1_sel       <= select;
        r_s1_mode      <= mode_control;
        r_s1_carry_in  <= carry_in;
        r_s1_acc_sel   <= acc_sel;
        r_s1_acc_write <= acc_write;
      end else if (w_s1_advance) begin
        r_s1_valid <= 1'b0;
      end
    end
  end

  // Accumulator updates on the same edge S1 hands off, so the next op in S1 sees it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid <= 1'b0;
      r_f        <= '0;
      r_cout     <= 1'b1;
      r_ovf      <= 1'b0;
      r_cmp      <= 1'b0;
      r_zero     <= 1'b0;
      r_acc      <= ACC_RESET;
    end else begin
      if (w_s1_advance) begin
        r_s2_valid <= 1'b1;
        r_f        <= w_f;
        r_cout     <= w_cout;
        r_ovf      <= w_ovf;
        r_cmp      <= &w_f;
        r_zero     <= ~|w_f;
        if (r_s1_acc_write) r_acc <= w_f;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid         = r_s2_valid;
  assign function_output   = r_f;
  assign carry_out         = r_cout;
  assign overflow          = r_ovf;
  assign comparator_output = r_cmp;
  assign zero_flag         = r_zero;
  assign accumulator       = r_acc;

endmodule

// File: tb/tb_alu_181_pipelined.sv
// Directed bench for alu_181_pipelined (WIDTH=8): vector table plus stream,
// stall, accumulator-chain and mid-stream reset sequences.
module tb_alu_181_pipelined;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic       mode;
    logic       cin_n;
    logic       acc_sel;
    logic       acc_write;
    logic [7:0] f;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] select = '0;
  logic       mode_control = 1'b0;
  logic       carry_in = 1'b0;
  logic       acc_sel = 1'b0;
  logic       acc_write = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] function_output;
  logic       carry_out;
  logic       overflow;
  logic       comparator_output;
  logic       zero_flag;
  logic [7:0] accumulator;

  int total = 0;
  int bad   = 0;

  vec_t       vecs[32];
  int         nvec = 0;
  vec_t       sin[8];
  logic [7:0] sexp[8];

  alu_181_pipelined #(.WIDTH(8), .ACC_RESET(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .select(select), .mode_control(mode_control), .carry_in(carry_in),
    .acc_sel(acc_sel), .acc_write(acc_write), .out_valid(out_valid), .out_ready(out_ready),
    .function_output(function_output), .carry_out(carry_out), .overflow(overflow),
    .comparator_output(comparator_output), .zero_flag(zero_flag), .accumulator(accumulator)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] va, input logic [7:0] vb, input logic [3:0] vs,
                              input logic vm, input logic vc, input logic [7:0] vf,
                              input logic vco, input logic vov);
    vec_t v;
    v.a = va; v.b = vb; v.sel = vs; v.mode = vm; v.cin_n = vc;
    v.acc_sel = 1'b0; v.acc_write = 1'b0;
    v.f = vf; v.cout = vco; v.ovf = vov;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    a = v.a; b = v.b; select = v.sel; mode_control = v.mode; carry_in = v.cin_n;
    acc_sel = v.acc_sel; acc_write = v.acc_write;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int lat;
    lat = -1;
    @(negedge clk);
    apply(v);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    chk({name, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_latency"}, lat, 1);
    chk({name, "_f"}, function_output, v.f);
    chk({name, "_cout"}, carry_out, v.cout);
    chk({name, "_ovf"}, overflow, v.ovf);
    chk({name, "_cmp"}, comparator_output, (v.f == 8'hFF));
    chk({name, "_zero"}, zero_flag, (v.f == 8'h00));
  endtask

  task automatic run_stream(input string tag, input int n_ops, input int stall_cycles);
    int issued;
    int got;
    issued = 0;
    got    = 0;
    for (int cyc = 0; cyc < 40 && got < n_ops; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= stall_cycles);
      if (issued < n_ops) begin
        apply(sin[issued]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (cyc >= 2 && cyc < stall_cycles && n_ops >= 3)
        chk($sformatf("%s_in_ready_c%0d", tag, cyc), in_ready, 0);
      if (out_valid) begin
        if (!out_ready) begin
          chk($sformatf("%s_hold_c%0d", tag, cyc), function_output, sexp[got]);
        end else begin
          chk($sformatf("%s_out%0d", tag, got), function_output, sexp[got]);
          got++;
        end
      end
      if (in_valid && in_ready) issued++;
    end
    chk({tag, "_count"}, got, n_ops);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[nvec++] = mk(8'h7F, 8'h01, 4'h9, 1'b0, 1'b0, 8'h81, 1'b1, 1'b1);
    vecs[nvec++] = mk(8'h3C, 8'h3C, 4'h6, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'h12, 8'h34, 4'h3, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'h12, 8'h34, 4'h3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    vecs[nvec++] = mk(8'hFF, 8'h01, 4'h9, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    vecs[nvec++] = mk(8'h80, 8'h80, 4'h9, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    vecs[nvec++] = mk(8'h00, 8'h00, 4'hF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'h10, 8'h05, 4'h6, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0);
    vecs[nvec++] = mk(8'h40, 8'h00, 4'hC, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    vecs[nvec++] = mk(8'h33, 8'h00, 4'h0, 1'b0, 1'b0, 8'h34, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h4, 1'b0, 1'b1, 8'h45, 1'b0, 1'b1);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h0, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h1, 1'b1, 1'b1, 8'h50, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h2, 1'b1, 1'b0, 8'h0A, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h3, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h4, 1'b1, 1'b0, 8'hFA, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h5, 1'b1, 1'b1, 8'hF0, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h6, 1'b1, 1'b0, 8'hAA, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h7, 1'b1, 1'b1, 8'hA0, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h8, 1'b1, 1'b0, 8'h5F, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'h9, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hA, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hB, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hC, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hD, 1'b1, 1'b1, 8'hF5, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hE, 1'b1, 1'b0, 8'hAF, 1'b1, 1'b0);
    vecs[nvec++] = mk(8'hA5, 8'h0F, 4'hF, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_f", function_output, 8'h00);
    chk("rst_cout", carry_out, 1);
    chk("rst_ovf", overflow, 0);
    chk("rst_cmp", comparator_output, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_acc", accumulator, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready_after", in_ready, 1);

    for (int i = 0; i < nvec; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // accumulator chain: acc + 0x10 four times, back to back
    for (int i = 0; i < 4; i++) begin
      sin[i] = mk(8'hEE, 8'h10, 4'h9, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
      sin[i].acc_sel   = 1'b1;
      sin[i].acc_write = 1'b1;
    end
    sexp[0] = 8'h10; sexp[1] = 8'h20; sexp[2] = 8'h30; sexp[3] = 8'h40;
    run_stream("chain", 4, 0);
    chk("chain_acc", accumulator, 8'h40);

    // downstream stall for 5 cycles with 3 ops
    sin[0] = mk(8'h01, 8'h01, 4'h9, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    sin[1] = mk(8'h03, 8'h03, 4'h9, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    sin[2] = mk(8'h05, 8'h05, 4'h9, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    sexp[0] = 8'h02; sexp[1] = 8'h06; sexp[2] = 8'h0A;
    run_stream("stall", 3, 5);
    chk("stall_acc", accumulator, 8'h40);

    // reset mid-stream with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    apply(mk(8'h11, 8'h00, 4'hF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    acc_write = 1'b1;
    in_valid  = 1'b1;
    @(negedge clk);
    apply(mk(8'h22, 8'h00, 4'hF, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0));
    acc_write = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_out_valid", out_valid, 1);
    chk("mid_acc_held", accumulator, 8'h11);
    chk("mid_in_ready", in_ready, 0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_acc", accumulator, 8'h00);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_cout", carry_out, 1);
    chk("mid_rst_f", function_output, 8'h00);
    @(negedge clk);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_no_stale%0d", i), out_valid, 0);
    end
    chk("post_rst_acc", accumulator, 8'h00);
    chk("post_rst_in_ready", in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
